// File: rtl/stp_frame_rcv.sv
// Start/stop serial frame receiver with mid-bit sampling, overrun and framing detection.
// Optional even-parity checking is enabled by defining PARITY_CHECK_EN.
module stp_frame_rcv #(
  parameter int NUM_BITS  = 4,
  parameter int BIT_CLKS  = 4,
  parameter int SHIFT_MSB = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                data_read,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                data_ready,
  output logic                framing_error,
  output logic                parity_error,
  output logic                overrun_error
);

  localparam int HALF = BIT_CLKS / 2;
  localparam int CW   = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int BW   = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    LOAD
  } state_t;

  state_t              state;
  logic                sync_1, sync, sync_prev;
  logic [CW-1:0]       clk_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [NUM_BITS-1:0] shreg;

  // Only a real 1->0 edge of the synchronized line may open a frame, so a
  // line stuck low after a bad frame is never mistaken for a new start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sync_1        <= 1'b1;
      sync          <= 1'b1;
      sync_prev     <= 1'b1;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      sync_1    <= serial_in;
      sync      <= sync_1;
      sync_prev <= sync;

      if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sync_prev && !sync) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == CW'(HALF - 1)) begin
            clk_cnt <= '0;
            if (sync) begin
              state <= IDLE;
            end else begin
              framing_error <= 1'b0;
`ifdef PARITY_CHECK_EN
              parity_error  <= 1'b0;
`endif
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CW'(BIT_CLKS - 1)) begin
            clk_cnt <= '0;
            if (SHIFT_MSB != 0) shreg <= {shreg[NUM_BITS-2:0], sync};
            else                shreg <= {sync, shreg[NUM_BITS-1:1]};
            if (bit_cnt == BW'(NUM_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (clk_cnt == CW'(BIT_CLKS - 1)) begin
            clk_cnt      <= '0;
            parity_error <= ^{shreg, sync};
            state        <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (clk_cnt == CW'(BIT_CLKS - 1)) begin
            clk_cnt <= '0;
            if (sync) begin
              state <= LOAD;
            end else begin
              framing_error <= 1'b1;
              state         <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        // A load in the same cycle as an acknowledge keeps the new data pending.
        LOAD: begin
          rx_data    <= shreg;
          data_ready <= 1'b1;
          if (data_ready && !data_read) overrun_error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_error = 1'b0;
`endif

endmodule
